// File: rtl/frog_step_controller_pkg.sv
// rtl/frog_step_controller_pkg.sv - shared game grid constants, FSM state and move direction encodings
package frog_step_controller_pkg;

    localparam int GRID_STEP    = 32;
    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int GRID_START_X = 320;
    localparam int GRID_START_Y = 448;

    typedef enum logic [1:0] {
        ST_WAIT_RELEASE = 2'd0,
        ST_READY        = 2'd1,
        ST_HELD         = 2'd2
    } frog_state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } frog_dir_e;

    // Bit 0 is up, bit 3 is right; lower index wins.
    function automatic frog_dir_e pick_dir(input logic [3:0] press);
        if (press[0])      return DIR_UP;
        else if (press[1]) return DIR_DOWN;
        else if (press[2]) return DIR_LEFT;
        else               return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/frog_step_controller_switch_debounce.sv
// rtl/frog_step_controller_switch_debounce.sv - 2-FF synchroniser, stable-count debouncer and rising-edge pulse for one switch
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic sync_o,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronised value agrees with the level restarts the count.
    always_comb begin
        sync_d  = {sync_q[0], raw_i};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= 2'b00;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync_q       <= sync_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign sync_o  = sync_q[1];
    assign level_o = level_q;
    assign rise_o  = level_q & ~level_prev_q;

endmodule

// File: rtl/frog_step_controller.sv
// rtl/frog_step_controller.sv - switch-to-grid frog mover; define FROG_AUTOREPEAT_EN for held-switch auto-repeat
module frog_step_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP            = frog_step_controller_pkg::GRID_STEP,
    parameter int START_X         = frog_step_controller_pkg::GRID_START_X,
    parameter int START_Y         = frog_step_controller_pkg::GRID_START_Y,
    parameter int MAX_X           = 608,
    parameter int MAX_Y           = 448,
    parameter int REPEAT_DELAY    = 6250000,
    parameter int REPEAT_PERIOD   = 3125000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch1,
    input  logic       switch2,
    input  logic       switch3,
    input  logic       switch4,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic       move_pulse,
    output logic       blocked_pulse
);

    import frog_step_controller_pkg::*;

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("frog_step_controller: cycle counts must be at least 1");
    end

    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] MAX_X_S = 11'(MAX_X);
    localparam logic signed [10:0] MAX_Y_S = 11'(MAX_Y);

    logic [3:0] raw_sw, sync_sw, level_sw, press_sw;
    logic       all_low, all_high, ready_go;

    assign raw_sw = {switch4, switch3, switch2, switch1};

    for (genvar i = 0; i < 4; i++) begin : g_sw
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (raw_sw[i]),
            .sync_o (sync_sw[i]),
            .level_o(level_sw[i]),
            .rise_o (press_sw[i])
        );
    end

    assign all_low  = ~|level_sw;
    assign all_high = &level_sw;
    assign ready_go = ~all_high & (|press_sw);

    frog_state_e state_q, state_d;
    frog_dir_e   attempt_dir;
    logic        attempt;
    logic        repeat_fire;
    logic [1:0]  settle_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_WAIT_RELEASE;
            settle_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            settle_q <= {settle_q[0], 1'b1};
        end
    end

    // Debounced levels read all-low straight after reset even when a switch is
    // still held; also wait for the synchronisers to carry real samples and be low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_RELEASE: if (all_low && settle_q[1] && (sync_sw == 4'b0000)) state_d = ST_READY;
            ST_READY:        if (all_high || (|press_sw)) state_d = ST_HELD;
            ST_HELD:         if (all_low) state_d = ST_READY;
            default:         state_d = ST_WAIT_RELEASE;
        endcase
    end

`ifdef FROG_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic             winner_q, winner_d;
    frog_dir_e        dir_q, dir_d;

    // winner_q stays low when READY left via the all-high path: nothing to repeat.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        winner_d    = winner_q;
        dir_d       = dir_q;
        repeat_fire = 1'b0;
        case (state_q)
            ST_READY: begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
                winner_d    = ready_go;
                if (ready_go) dir_d = pick_dir(press_sw);
            end
            ST_HELD: begin
                if (winner_q && level_sw[dir_q]) begin
                    if (rep_cnt_q == (rep_first_q ? REP_FIRST : REP_NEXT)) begin
                        repeat_fire = 1'b1;
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end else begin
                    rep_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
            winner_q    <= 1'b0;
            dir_q       <= DIR_UP;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            winner_q    <= winner_d;
            dir_q       <= dir_d;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_comb begin
        attempt     = 1'b0;
        attempt_dir = pick_dir(press_sw);
        case (state_q)
            ST_READY: attempt = ready_go;
            ST_HELD: begin
                attempt = repeat_fire;
`ifdef FROG_AUTOREPEAT_EN
                attempt_dir = dir_q;
`endif
            end
            default: ;
        endcase
    end

    logic [9:0]         x_q, x_d, y_q, y_d;
    logic               move_q, move_d, blocked_q, blocked_d;
    logic signed [10:0] cand_x, cand_y;
    logic               legal;

    always_comb begin
        cand_x = $signed({1'b0, x_q});
        cand_y = $signed({1'b0, y_q});
        case (attempt_dir)
            DIR_UP:    cand_y = cand_y - STEP_S;
            DIR_DOWN:  cand_y = cand_y + STEP_S;
            DIR_LEFT:  cand_x = cand_x - STEP_S;
            default:   cand_x = cand_x + STEP_S;
        endcase
        legal = (cand_x >= 11'sd0) && (cand_x <= MAX_X_S) &&
                (cand_y >= 11'sd0) && (cand_y <= MAX_Y_S);

        x_d       = x_q;
        y_d       = y_q;
        move_d    = 1'b0;
        blocked_d = 1'b0;
        if (attempt) begin
            if (legal) begin
                x_d    = cand_x[9:0];
                y_d    = cand_y[9:0];
                move_d = 1'b1;
            end else begin
                blocked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= 10'(START_X);
            y_q       <= 10'(START_Y);
            move_q    <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            move_q    <= move_d;
            blocked_q <= blocked_d;
        end
    end

    assign frog_x        = x_q;
    assign frog_y        = y_q;
    assign move_pulse    = move_q;
    assign blocked_pulse = blocked_q;

endmodule
